// File: rtl/rojobot_map_pkg.sv
// Shared map definitions for the rojobot world-map path: map codes and
// default geometry used by the fetch stage and the colorizer.
package rojobot_map_pkg;

  typedef logic [1:0] map_code_t;

  localparam map_code_t MAP_GRASS  = 2'b00;
  localparam map_code_t MAP_ROAD   = 2'b01;
  localparam map_code_t MAP_FLOWER = 2'b10;
  localparam map_code_t MAP_BLACK  = 2'b11;

  localparam int DEF_CELL_SHIFT = 3;
  localparam int DEF_MAP_COLS   = 128;
  localparam int DEF_MAP_ROWS   = 128;
  localparam int PIX_W          = 12;

endpackage

// File: rtl/world_map_fetch_pipe_delay.sv
// Fixed-depth register delay line, asynchronously cleared to zero.
// DEPTH must be at least 1.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q <= '0;
          else       stage_q <= d_i;
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q <= '0;
          else       stage_q <= g_stage[gi-1].stage_q;
        end
      end
    end
  endgenerate

  assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/world_map_fetch.sv
// Scan-pixel to world-map fetch stage: issues RAM reads per map cell, skips
// repeat reads of the same cell, and realigns pixel info with the returned data.
module world_map_fetch
  import rojobot_map_pkg::*;
#(
  parameter int        CELL_SHIFT  = DEF_CELL_SHIFT,
  parameter int        MAP_COLS    = DEF_MAP_COLS,
  parameter int        MAP_ROWS    = DEF_MAP_ROWS,
  parameter int        ADDR_W      = 14,
  parameter int        RAM_LATENCY = 1,
  parameter map_code_t OOR_VALUE   = MAP_BLACK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       pixel_row,
  input  logic [11:0]       pixel_column,
  input  logic              video_on,
  output logic [ADDR_W-1:0] map_addr,
  output logic              map_rd_en,
  input  logic [1:0]        map_data,
  output logic [1:0]        map_value,
  output logic [11:0]       map_row,
  output logic [11:0]       map_column,
  output logic              map_video_on
);

  localparam int ROW_W = $clog2(MAP_ROWS);
  localparam int COL_W = $clog2(MAP_COLS);
  localparam int BUS_W = 1 + 2 * PIX_W + 1;
  localparam logic [12:0] ROWS_LIM = 13'(MAP_ROWS);
  localparam logic [12:0] COLS_LIM = 13'(MAP_COLS);

  logic [11:0]       cell_row;
  logic [11:0]       cell_col;
  logic              in_range;
  logic              fetch_d;
  logic [ADDR_W-1:0] addr_d;
  logic              rd_en_d;
  logic [ADDR_W-1:0] last_addr_d;
  logic              last_valid_d;

  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              last_valid_q;
  logic [BUS_W-1:0]  stage_a_q;
  logic [BUS_W-1:0]  stage_a_d;
  logic [BUS_W-1:0]  dly_bus;

  logic              dly_fetch;
  logic [11:0]       dly_row;
  logic [11:0]       dly_col;
  logic              dly_von;

  logic [1:0]        value_q;
  logic [11:0]       row_q;
  logic [11:0]       col_q;
  logic              von_q;

  assign cell_row = pixel_row >> CELL_SHIFT;
  assign cell_col = pixel_column >> CELL_SHIFT;

  // Range test happens on the full cell index so wrapped addresses never alias in.
  always_comb begin
    in_range     = ({1'b0, cell_row} < ROWS_LIM) && ({1'b0, cell_col} < COLS_LIM);
    fetch_d      = video_on && in_range;
    addr_d       = ADDR_W'({cell_row[ROW_W-1:0], cell_col[COL_W-1:0]});
    rd_en_d      = fetch_d && !(last_valid_q && (addr_d == last_addr_q));
    last_addr_d  = fetch_d ? addr_d : last_addr_q;
    last_valid_d = fetch_d;
    stage_a_d    = {fetch_d, pixel_row, pixel_column, video_on};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      stage_a_q    <= '0;
    end else begin
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      stage_a_q    <= stage_a_d;
    end
  end

  pipe_delay #(
    .WIDTH (BUS_W),
    .DEPTH (RAM_LATENCY)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d_i   (stage_a_q),
    .q_o   (dly_bus)
  );

  assign {dly_fetch, dly_row, dly_col, dly_von} = dly_bus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= OOR_VALUE;
      row_q   <= '0;
      col_q   <= '0;
      von_q   <= 1'b0;
    end else begin
      value_q <= dly_fetch ? map_data : OOR_VALUE;
      row_q   <= dly_row;
      col_q   <= dly_col;
      von_q   <= dly_von;
    end
  end

  assign map_addr     = addr_q;
  assign map_rd_en    = rd_en_q;
  assign map_value    = value_q;
  assign map_row      = row_q;
  assign map_column   = col_q;
  assign map_video_on = von_q;

endmodule

// File: tb/tb_world_map_fetch.sv
// Directed bench for world_map_fetch: latency-1 and latency-3 builds side by
// side, each fed by a RAM model whose cell value is the low two address bits.
module tb_world_map_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic        video_on;

  logic [13:0] addr1, addr3;
  logic        rd1, rd3;
  logic [1:0]  data1, data3;
  logic [1:0]  val1, val3;
  logic [11:0] row1, row3, col1, col3;
  logic        von1, von3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  world_map_fetch #(.RAM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .video_on(video_on), .map_addr(addr1), .map_rd_en(rd1), .map_data(data1),
    .map_value(val1), .map_row(row1), .map_column(col1), .map_video_on(von1)
  );

  world_map_fetch #(.RAM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .video_on(video_on), .map_addr(addr3), .map_rd_en(rd3), .map_data(data3),
    .map_value(val3), .map_row(row3), .map_column(col3), .map_video_on(von3)
  );

  // RAM models: output updates only on a read and holds otherwise.
  always @(posedge clk) begin
    if (rd1) data1 <= addr1[1:0];
  end

  logic        p0_en = 1'b0, p1_en = 1'b0;
  logic [13:0] p0_a = '0, p1_a = '0;
  always @(posedge clk) begin
    p0_en <= rd3;
    p0_a  <= addr3;
    p1_en <= p0_en;
    p1_a  <= p0_a;
    if (p1_en) data3 <= p1_a[1:0];
  end

  typedef struct {
    logic [11:0] row;
    logic [11:0] col;
    logic        von;
    logic [13:0] e_addr;
    logic        e_rd;
    logic [1:0]  e_val;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int r, input int c, input bit v, input int a, input bit rd, input int val);
    vec_t x;
    x.row = 12'(r); x.col = 12'(c); x.von = v;
    x.e_addr = 14'(a); x.e_rd = rd; x.e_val = 2'(val);
    vecs.push_back(x);
  endtask

  task automatic drive(input int r, input int c, input bit v);
    pixel_row = 12'(r); pixel_column = 12'(c); video_on = v;
  endtask

  initial begin
    vec_t v;
    int n;

    // Line sweep, row 0, cells 0 and 1
    for (int c = 0; c < 16; c++) add(0, c, 1'b1, c >> 3, (c == 0) || (c == 8), c >> 3);
    add(37, 1000, 1, 637, 1, 1);   // address packing {4,125}
    add(37, 1024, 1, 512, 0, 3);   // column boundary: off map
    add(37, 1000, 1, 637, 1, 1);   // reissued read after off-map
    add(37, 1001, 1, 637, 0, 1);   // same cell, RAM holds data
    add(37, 1002, 0, 637, 0, 3);   // blanked pixel
    add(37, 1003, 1, 637, 1, 1);   // read reissued after blanking
    add(0, 1023, 1, 127, 1, 3);    // last in-map column
    add(1024, 0, 1, 0, 0, 3);      // row boundary: off map
    add(8, 16, 1, 130, 1, 2);
    add(9, 23, 1, 130, 0, 2);
    add(4095, 4095, 1, 16383, 0, 3);
    add(9, 23, 1, 130, 1, 2);
    add(0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 3);

    // Reset held with video_on high
    reset = 1'b1;
    drive(3, 3, 1'b1);
    repeat (4) @(negedge clk);
    check("rst rd1", rd1, 0);        check("rst rd3", rd3, 0);
    check("rst addr1", addr1, 0);    check("rst val1", val1, 3);
    check("rst val3", val3, 3);      check("rst von1", von1, 0);
    check("rst von3", von3, 0);      check("rst row1", row1, 0);
    check("rst col1", col1, 0);
    drive(0, 0, 1'b0);
    reset = 1'b0;

    n = vecs.size();
    for (int k = 0; k < n + 5; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        v = vecs[k-1];
        check($sformatf("addr1[%0d]", k-1), addr1, v.e_addr);
        check($sformatf("rd1[%0d]", k-1), rd1, v.e_rd);
        check($sformatf("addr3[%0d]", k-1), addr3, v.e_addr);
        check($sformatf("rd3[%0d]", k-1), rd3, v.e_rd);
      end
      if (k >= 3 && k - 3 < n) begin
        v = vecs[k-3];
        check($sformatf("val1[%0d]", k-3), val1, v.e_val);
        check($sformatf("row1[%0d]", k-3), row1, v.row);
        check($sformatf("col1[%0d]", k-3), col1, v.col);
        check($sformatf("von1[%0d]", k-3), von1, v.von);
      end
      if (k >= 5) begin
        v = vecs[k-5];
        check($sformatf("val3[%0d]", k-5), val3, v.e_val);
        check($sformatf("row3[%0d]", k-5), row3, v.row);
        check($sformatf("col3[%0d]", k-5), col3, v.col);
        check($sformatf("von3[%0d]", k-5), von3, v.von);
      end
      if (k < n) drive(vecs[k].row, vecs[k].col, vecs[k].von);
      else       drive(0, 0, 1'b0);
    end

    // Reset asserted mid-line, away from any clock edge
    @(negedge clk);
    drive(5, 100, 1'b1);
    repeat (6) @(negedge clk);
    check("pre-rst von1", von1, 1);
    check("pre-rst row1", row1, 5);
    #2 reset = 1'b1;
    #1;
    check("async val1", val1, 3);   check("async von1", von1, 0);
    check("async row1", row1, 0);   check("async col1", col1, 0);
    check("async addr1", addr1, 0); check("async val3", val3, 3);
    check("async von3", von3, 0);   check("async col3", col3, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check($sformatf("rel rd1[%0d]", j), rd1, (j == 1) ? 1 : 0);
      check($sformatf("rel von1[%0d]", j), von1, (j >= 3) ? 1 : 0);
      check($sformatf("rel val1[%0d]", j), val1, (j >= 3) ? 0 : 3);
      check($sformatf("rel von3[%0d]", j), von3, (j >= 5) ? 1 : 0);
      check($sformatf("rel val3[%0d]", j), val3, (j >= 5) ? 0 : 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
